// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared widths, reset divider and FSM encoding for the SPI master
package spi_pkg;

  localparam int unsigned SPI_DIV_W = 8;
  localparam logic [SPI_DIV_W-1:0] SPI_DIV_RST = 8'd1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } spi_clkgen_state_e;

endpackage

// File: rtl/spi_clkgen.sv
// rtl/spi_clkgen.sv - SCK divider and rx/tx edge strobes; always stops on a full SCK period
module spi_clkgen
  import spi_pkg::*;
#(
  parameter int unsigned          DIV_W   = SPI_DIV_W,
  parameter logic [DIV_W-1:0]     DIV_RST = DIV_W'(SPI_DIV_RST)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic [DIV_W-1:0] clk_div,
  input  logic             clk_div_valid,
  input  logic             cpol,
  input  logic             cpha,
  output logic             spi_clk,
  output logic             rx_edge,
  output logic             tx_edge,
  output logic             busy
);

  spi_clkgen_state_e state_q, state_d;
  logic             phase_q, phase_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] div_pend_q, div_pend_d;
  logic             pend_q, pend_d;
  logic             cpol_q, cpha_q;

  logic running, toggle, lead, trail;

  assign running = (state_q != IDLE);
  assign toggle  = running && (cnt_q == div_q);
  assign lead    = toggle && !phase_q;
  assign trail   = toggle && phase_q;

  assign rx_edge = cpha_q ? trail : lead;
  assign tx_edge = cpha_q ? lead : trail;
  assign busy    = running || phase_q;
  assign spi_clk = phase_q ^ cpol_q;

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    if (toggle) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end else if (running) begin
      cnt_d = cnt_q + DIV_W'(1);
    end
    case (state_q)
      IDLE: begin
        cnt_d   = '0;
        phase_d = 1'b0;
        if (en) state_d = RUN;
      end
      RUN: begin
        // Leaving RUN ends at the idle level directly, otherwise drain the open half-period
        if (!en) begin
          if (!phase_d) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (en)         state_d = RUN;
        else if (trail) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    div_d      = div_q;
    div_pend_d = div_pend_q;
    pend_d     = pend_q;
    if (!busy) begin
      if (clk_div_valid) begin
        div_d  = clk_div;
        pend_d = 1'b0;
      end else if (pend_q) begin
        div_d  = div_pend_q;
        pend_d = 1'b0;
      end
    end else if (clk_div_valid) begin
      div_pend_d = clk_div;
      pend_d     = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      phase_q    <= 1'b0;
      cnt_q      <= '0;
      div_q      <= DIV_RST;
      div_pend_q <= '0;
      pend_q     <= 1'b0;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      div_pend_q <= div_pend_d;
      pend_q     <= pend_d;
      if (!busy) begin
        cpol_q <= cpol;
        cpha_q <= cpha;
      end
    end
  end

endmodule
